regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the two write ports of the 32x32 register file among NUM_REQ independent requesters.
- Each cycle it grants up to two requests, round-robin, onto write port 1 and write port 2.
- It never issues two same-index writes in one cycle, so the file's same-index tie-break never drops data.
- Outputs are registered on posedge clock and drive the file's write1/write2 ports directly. The file captures them on the following negedge.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8. PTR_W = $clog2(NUM_REQ) is derived internally.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- clear  in  1  synchronous active-high reset.
- req  in  NUM_REQ  per-requester write request; held with index/data until ack.
- req_index  in  NUM_REQ*5  packed target indices; requester i uses bits [5i+4:5i].
- req_data  in  NUM_REQ*32  packed write data; requester i uses bits [32i+31:32i].
- ack  out  NUM_REQ  one-cycle grant pulse per requester.
- write1  out  1  port-1 write enable to the file.
- writeIndex1  out  5  port-1 index.
- writeData1  out  32  port-1 data.
- write2  out  1  port-2 write enable.
- writeIndex2  out  5  port-2 index.
- writeData2  out  32  port-2 data.

Behaviour:
- Reset (clear=1 at posedge): ack=0, write1=write2=0, writeIndex1/2=0, writeData1/2=0, rr_ptr=0. Clear wins over any request in the same cycle.
- Reset mid-operation: an in-flight ack/write is cancelled, because outputs are zeroed. Requests still asserted are re-arbitrated from rr_ptr=0 after clear drops.
- Eligibility: requester i is eligible when req[i]=1 and ack[i]=0. This masks the cycle in which its registered ack is visible, so it is never double-granted.
- Requester contract: after seeing ack[i]=1, the requester drops req[i] or presents a new request in the next cycle.
- Winner A: first eligible requester scanning i = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
- Winner B: first eligible requester scanning from A+1 up to rr_ptr-1 (mod NUM_REQ), excluding any whose req_index equals A's index.
  - Excluded requesters stay pending and are not acked.
- Outputs at the next posedge:
  - write1=1 with A's index/data, ack[A]=1.
  - write2=1 with B's index/data, ack[B]=1.
  - Absent winners give write=0. Index/data of a disabled port hold their previous value (don't-care to the file).
- Latency: request eligible in cycle N produces write/ack registered at the end of cycle N, visible in cycle N+1. Minimum re-request spacing for one requester is 2 cycles.
- Throughput: up to 2 writes/cycle with distinct indices.
- Pointer update:
  - rr_ptr <= (last granted + 1) mod NUM_REQ, where last granted is B if present, else A.
  - No grant: rr_ptr holds.
- Fairness: any continuously asserted request is granted within ceil(NUM_REQ/2) + NUM_REQ cycles, worst case including the same-index exclusions.
- Wrap-around: scans are modulo NUM_REQ. With NUM_REQ=2 and both eligible, both are granted in one cycle unless the indices match.
- Only one eligible requester: port 1 only; write2=0.

Optional Feature:
- Macro: ARB_CONFLICT_CNT_EN.
- Defined:
  - Adds output conflict_count [15:0], reset to 0 by clear.
  - Increments by 1 each cycle in which at least one eligible requester was excluded from B for a same-index match with A.
  - Saturates at 16'hFFFF.
- Undefined: port and counter absent; arbitration identical.

Test Plan:
- clear=1 for 2 cycles with req=4'b1111 -> ack=0, write1=write2=0, all indices/data 0; rr_ptr=0 after release.
- From reset, req=4'b0101; idx0=3, data0=243; idx2=7, data2=71 -> next cycle write1=1/idx3/243, write2=1/idx7/71, ack=4'b0101; rr_ptr=3; file readIndex 3 and 7 return 243 and 71.
- req=4'b0011; idx0=idx1=2; data0=741, data1=12 -> cycle 1: port1=(2,741), write2=0, ack=4'b0001. Cycle 2: port1=(2,12), ack=4'b0010. File index 2 ends at 12; with ARB_CONFLICT_CNT_EN, conflict_count=1.
- All 4 requests held continuously with distinct indices 4..7 -> grants alternate {0,1}, {2,3}, {0,1} on re-request; each requester gets 1 grant per 2 cycles; no ack in consecutive cycles for the same requester.
- Single requester 3 alone (idx 31, data 32'hFFFFFFFF) held 4 cycles -> writes in cycles 1 and 3 only on port 1, write2 stays 0, ack[3] pulses in alternate cycles.
- Assert clear in the cycle after a grant while req=4'b1000 -> outputs forced to 0 that edge; after clear drops, requester 3 is granted again one cycle later.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_if
//   Bundles the requester side and the register-file write side of the
//   write arbiter.
//
//   Parameter
//     NUM_REQ      number of requesters (2..8)
//
//   Signals
//     req          per-requester write request, held with index/data until ack
//     req_index    packed 5-bit target indices, requester i at [5i+4:5i]
//     req_data     packed 32-bit write data, requester i at [32i+31:32i]
//     ack          one-cycle grant pulse per requester
//     write1/2     write enables to the register file ports
//     writeIndex1/2, writeData1/2  index/data for those ports
//
//   Modports
//     master       requesters plus register file (drives requests, sees grants)
//     slave        the arbiter
// -----------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*5-1:0]  req_index;
    logic [NUM_REQ*32-1:0] req_data;
    logic [NUM_REQ-1:0]    ack;
    logic                  write1;
    logic [4:0]            writeIndex1;
    logic [31:0]           writeData1;
    logic                  write2;
    logic [4:0]            writeIndex2;
    logic [31:0]           writeData2;

    modport master (
        output req, req_index, req_data,
        input  ack, write1, writeIndex1, writeData1, write2, writeIndex2, writeData2
    );

    modport slave (
        input  req, req_index, req_data,
        output ack, write1, writeIndex1, writeData1, write2, writeIndex2, writeData2
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//   Shares the two write ports of the 32x32 register file among NUM_REQ
//   requesters. Each cycle up to two requests are granted round-robin: winner
//   A goes to port 1, winner B to port 2. B never carries the same index as A,
//   so the file never has to tie-break two writes to one register.
//   Outputs are registered on posedge clock; the file captures them on the
//   following negedge.
//
//   Ports
//     clock        system clock, all state on posedge
//     clear        synchronous active-high reset
//     bus          regfile_write_arbiter_if.slave (requests in, acks/writes out)
//     conflict_count [15:0]  only with ARB_CONFLICT_CNT_EN defined: saturating
//                  count of cycles where an eligible requester was held off
//                  port 2 because its index matched port 1's
//
//   Build option
//     ARB_CONFLICT_CNT_EN  adds the conflict counter; arbitration is unchanged
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                   clock,
    input  logic                   clear,
    regfile_write_arbiter_if.slave bus
`ifdef ARB_CONFLICT_CNT_EN
    ,
    output logic [15:0]            conflict_count
`endif
);
    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   r_rr_ptr;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_write1;
    logic               r_write2;
    logic [4:0]         r_index1;
    logic [4:0]         r_index2;
    logic [31:0]        r_data1;
    logic [31:0]        r_data2;

    logic [4:0]         w_idx  [NUM_REQ];
    logic [31:0]        w_data [NUM_REQ];
    logic [NUM_REQ-1:0] w_elig;
    logic               w_a_vld;
    logic               w_b_vld;
    logic [PTR_W-1:0]   w_a;
    logic [PTR_W-1:0]   w_b;
    logic [PTR_W-1:0]   w_slot;
    int unsigned        w_a_off;
`ifdef ARB_CONFLICT_CNT_EN
    logic               w_conflict;
    logic [15:0]        r_conflict_count;
`endif

    // Requester sitting 'k' places after 'base' in round-robin order.
    function automatic logic [PTR_W-1:0] slot(input logic [PTR_W-1:0] base,
                                              input int unsigned      k);
        return PTR_W'((32'(base) + k) % NUM_REQ);
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_idx[g]  = bus.req_index[5*g +: 5];
        assign w_data[g] = bus.req_data[32*g +: 32];
    end

    always_comb begin
        // A requester whose ack is currently visible is masked so it cannot
        // be granted twice for the same request.
        w_elig  = bus.req & ~r_ack;
        w_a_vld = 1'b0;
        w_a     = '0;
        w_a_off = 0;
        w_b_vld = 1'b0;
        w_b     = '0;
        w_slot  = '0;
`ifdef ARB_CONFLICT_CNT_EN
        w_conflict = 1'b0;
`endif
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_slot = slot(r_rr_ptr, k);
            if (!w_a_vld && w_elig[w_slot]) begin
                w_a_vld = 1'b1;
                w_a     = w_slot;
                w_a_off = k;
            end
        end
        // B only looks at offsets beyond A, i.e. from A+1 up to rr_ptr-1.
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_slot = slot(r_rr_ptr, k);
            if (w_a_vld && (k > w_a_off) && w_elig[w_slot]) begin
                if (w_idx[w_slot] == w_idx[w_a]) begin
`ifdef ARB_CONFLICT_CNT_EN
                    w_conflict = 1'b1;
`endif
                end else if (!w_b_vld) begin
                    w_b_vld = 1'b1;
                    w_b     = w_slot;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_rr_ptr <= '0;
            r_ack    <= '0;
            r_write1 <= 1'b0;
            r_write2 <= 1'b0;
            r_index1 <= '0;
            r_index2 <= '0;
            r_data1  <= '0;
            r_data2  <= '0;
        end else begin
            r_ack    <= '0;
            r_write1 <= w_a_vld;
            r_write2 <= w_b_vld;
            // Index/data of an idle port keep their last value.
            if (w_a_vld) begin
                r_ack[w_a] <= 1'b1;
                r_index1   <= w_idx[w_a];
                r_data1    <= w_data[w_a];
            end
            if (w_b_vld) begin
                r_ack[w_b] <= 1'b1;
                r_index2   <= w_idx[w_b];
                r_data2    <= w_data[w_b];
            end
            if (w_b_vld) begin
                r_rr_ptr <= slot(w_b, 1);
            end else if (w_a_vld) begin
                r_rr_ptr <= slot(w_a, 1);
            end
        end
    end

`ifdef ARB_CONFLICT_CNT_EN
    always_ff @(posedge clock) begin
        if (clear) begin
            r_conflict_count <= '0;
        end else if (w_conflict && (r_conflict_count != 16'hFFFF)) begin
            r_conflict_count <= r_conflict_count + 16'd1;
        end
    end

    assign conflict_count = r_conflict_count;
`else
    // No conflict counter in this build.
`endif

    assign bus.ack         = r_ack;
    assign bus.write1      = r_write1;
    assign bus.writeIndex1 = r_index1;
    assign bus.writeData1  = r_data1;
    assign bus.write2      = r_write2;
    assign bus.writeIndex2 = r_index2;
    assign bus.writeData2  = r_data2;
endmodule
